// File: rtl/dp_pkg.sv
// Shared types and constants for the FX3 data-port scheduler.
package dp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CHK     = 3'd2,
        ST_STRT    = 3'd3,
        ST_WT_DONE = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    localparam logic [1:0] DP0 = 2'd0;
    localparam logic [1:0] DP1 = 2'd1;
    localparam logic [1:0] DP2 = 2'd2;
    localparam logic [1:0] DP3 = 2'd3;

    localparam logic [1:0] EP_DP0 = 2'd0;
    localparam logic [1:0] EP_DP1 = 2'd1;
    localparam logic [1:0] EP_DP2 = 2'd2;
    localparam logic [1:0] EP_DP3 = 2'd3;

    localparam logic [1:0] MUX_WR0 = 2'd0;
    localparam logic [1:0] MUX_WR1 = 2'd1;
    localparam logic [1:0] MUX_WR2 = 2'd2;

    // DP0 is the read port, so it shares the first write-strobe lane.
    function automatic logic [1:0] dp_mux_sel(input logic [1:0] idx);
        case (idx)
            DP0, DP1: return MUX_WR0;
            DP2:      return MUX_WR1;
            default:  return MUX_WR2;
        endcase
    endfunction

    function automatic logic [1:0] dp_ep_addr(input logic [1:0] idx);
        case (idx)
            DP0:     return EP_DP0;
            DP1:     return EP_DP1;
            DP2:     return EP_DP2;
            default: return EP_DP3;
        endcase
    endfunction

    function automatic logic [3:0] dp_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/dp_rr_pick.sv
// Combinational 4-way round-robin picker, searching from i_ptr+1.
module dp_rr_pick (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_idx
);

    logic [1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int i = 1; i <= 4; i++) begin
            w_cand = i_ptr + 2'(i);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/dp_sched.sv
// Request-driven round-robin scheduler for the four FX3 slave-FIFO ports.
module dp_sched
    import dp_pkg::*;
#(
    parameter int TURN_CYC = 2,
    parameter int TMO_CYC  = 4096,
    parameter int TMO_W    = 12
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [3:0] req_i,
    output logic [3:0] strt_o,
    input  logic [3:0] done_i,
    output logic [3:0] abort_o,
    input  logic       flag_rdy_i,
    output logic [1:0] SLADDR_o,
    output logic       SLOEn_o,
    output logic       SLCSn_o,
    output logic [1:0] dpoMuxSel_o,
    output logic       busy_o,
    output logic       tmo_o
);

    localparam logic [3:0]       TURN_LD  = 4'(TURN_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [3:0]       r_turn, w_turn_nxt;
    logic [TMO_W-1:0] r_wd, w_wd_nxt, w_wd_inc;
    logic             w_expire;
    logic             w_pick_v;
    logic [1:0]       w_pick_idx;
    logic             w_oe_act;

    logic [3:0] r_strt, r_abort;
    logic [1:0] r_sladdr, r_mux;
    logic       r_sloen, r_slcsn, r_busy, r_tmo;

    dp_rr_pick u_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_v),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_turn_nxt  = r_turn;
        w_wd_nxt    = r_wd;
        w_wd_inc    = r_wd + TMO_W'(1);
        w_expire    = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_state_nxt = ST_IDLE;
                if (w_pick_v) begin
                    w_grant_nxt = w_pick_idx;
                    w_ptr_nxt   = w_pick_idx;
                    w_turn_nxt  = TURN_LD;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (r_turn == 4'd0) w_state_nxt = ST_CHK;
                else                w_turn_nxt  = r_turn - 4'd1;
            end
            ST_CHK: begin
                if (!req_i[r_grant]) w_state_nxt = ST_IDLE;
                else if (flag_rdy_i) w_state_nxt = ST_STRT;
            end
            ST_STRT: begin
                w_wd_nxt    = '0;
                w_state_nxt = ST_WT_DONE;
            end
            ST_WT_DONE: begin
                w_wd_nxt = w_wd_inc;
                // A completion in the expiry cycle still counts as success.
                if (done_i[r_grant]) begin
                    w_state_nxt = ST_GAP;
                end else if (w_wd_inc == TMO_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_oe_act = (w_grant_nxt == DP0) &&
                      (w_state_nxt == ST_CHK ||
                       w_state_nxt == ST_STRT ||
                       w_state_nxt == ST_WT_DONE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= DP0;
            r_ptr    <= DP3;
            r_turn   <= '0;
            r_wd     <= '0;
            r_strt   <= '0;
            r_abort  <= '0;
            r_sladdr <= EP_DP0;
            r_sloen  <= 1'b1;
            r_slcsn  <= 1'b1;
            r_mux    <= MUX_WR0;
            r_busy   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            r_turn   <= w_turn_nxt;
            r_wd     <= w_wd_nxt;
            r_strt   <= (w_state_nxt == ST_STRT) ?
                        dp_onehot(w_grant_nxt) : '0;
            r_abort  <= w_expire ? dp_onehot(r_grant) : '0;
            r_tmo    <= w_expire;
            r_sloen  <= !w_oe_act;
            r_slcsn  <= (w_state_nxt == ST_IDLE);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_sladdr <= (w_state_nxt == ST_IDLE) ?
                        EP_DP0 : dp_ep_addr(w_grant_nxt);
            r_mux    <= (w_state_nxt == ST_IDLE) ?
                        MUX_WR0 : dp_mux_sel(w_grant_nxt);
        end
    end

    assign strt_o      = r_strt;
    assign abort_o     = r_abort;
    assign SLADDR_o    = r_sladdr;
    assign SLOEn_o     = r_sloen;
    assign SLCSn_o     = r_slcsn;
    assign dpoMuxSel_o = r_mux;
    assign busy_o      = r_busy;
    assign tmo_o       = r_tmo;

endmodule
